// File: rtl/launch_pkg.sv
// Shared types and constants for the core launcher and its run timer.
package launch_pkg;

    localparam int unsigned CYC_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CRST = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } launch_state_t;

endpackage

// File: rtl/core_launcher_if.sv
// Load stream, instruction-memory write port, core run handshake and status.
interface core_launcher_if #(
    parameter int unsigned D = 12,
    parameter int unsigned W = 9
);
    logic                          ld_valid;
    logic [W-1:0]                  ld_data;
    logic                          ld_last;
    logic                          ld_ready;
    logic                          go;
    logic                          im_wr_en;
    logic [D-1:0]                  im_addr;
    logic [W-1:0]                  im_dat;
    logic                          core_reset;
    logic                          core_req;
    logic                          core_done;
    logic                          busy;
    logic                          run_done;
    logic                          timeout;
    logic [launch_pkg::CYC_W-1:0]  cycles;
    logic [D-1:0]                  words;

    modport master (
        output ld_valid, ld_data, ld_last, go, core_done,
        input  ld_ready, im_wr_en, im_addr, im_dat, core_reset, core_req,
               busy, run_done, timeout, cycles, words
    );

    modport slave (
        input  ld_valid, ld_data, ld_last, go, core_done,
        output ld_ready, im_wr_en, im_addr, im_dat, core_reset, core_req,
               busy, run_done, timeout, cycles, words
    );
endinterface

// File: rtl/core_launcher_run_timer.sv
// RUN-cycle counter with clear/enable; limit_hit flags the cycle whose increment reaches MAX_CYC.
module run_timer
    import launch_pkg::*;
#(
    parameter int unsigned MAX_CYC = 4096
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    output logic [CYC_W-1:0] count,
    output logic             limit_hit
);

    logic [CYC_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + CYC_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Compare one bit wider so a limit of 65535 never wraps.
    assign limit_hit = ({1'b0, count_q} + 17'd1) == 17'(MAX_CYC);
    assign count     = count_q;

endmodule

// File: rtl/core_launcher.sv
// Loads a program into instruction memory, then runs the core through reset/req/done.
module core_launcher
    import launch_pkg::*;
#(
    parameter int unsigned D       = 12,
    parameter int unsigned W       = 9,
    parameter int unsigned RST_CYC = 2,
    parameter int unsigned MAX_CYC = 4096
) (
    input logic             clk,
    input logic             reset,
    core_launcher_if.slave  bus
);

    localparam int unsigned RW = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;

    launch_state_t  state_q, state_d;
    logic [RW-1:0]  rst_cnt_q, rst_cnt_d;
    logic [D-1:0]   wr_ptr_q, wr_ptr_d;
    logic [D-1:0]   words_q, words_d;
    logic           timeout_q, timeout_d;
    logic           accept, tmr_clr, tmr_en, limit_hit;
    logic [CYC_W-1:0] cycles;

    run_timer #(.MAX_CYC(MAX_CYC)) u_timer (
        .clk       (clk),
        .reset     (reset),
        .clr       (tmr_clr),
        .en        (tmr_en),
        .count     (cycles),
        .limit_hit (limit_hit)
    );

    always_comb begin
        state_d   = state_q;
        rst_cnt_d = rst_cnt_q;
        timeout_d = timeout_q;
        tmr_clr   = 1'b0;
        tmr_en    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.go) begin
                    timeout_d = 1'b0;
                    tmr_clr   = 1'b1;
                    rst_cnt_d = RW'(RST_CYC - 1);
                    state_d   = CRST;
                end
            end
            CRST: begin
                if (rst_cnt_q == '0) begin
                    state_d = RUN;
                end else begin
                    rst_cnt_d = rst_cnt_q - RW'(1);
                end
            end
            RUN: begin
                tmr_en = 1'b1;
                if (bus.core_done) begin
                    state_d = DONE;
                end else if (limit_hit) begin
                    timeout_d = 1'b1;
                    state_d   = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // go wins over a same-cycle load word: ld_ready drops, so nothing is written.
    always_comb begin
        accept   = (state_q == IDLE) && !bus.go && bus.ld_valid;
        wr_ptr_d = wr_ptr_q;
        words_d  = words_q;
        if (accept) begin
            if (bus.ld_last) begin
                words_d  = wr_ptr_q + D'(1);
                wr_ptr_d = '0;
            end else begin
                wr_ptr_d = wr_ptr_q + D'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            rst_cnt_q <= '0;
            wr_ptr_q  <= '0;
            words_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rst_cnt_q <= rst_cnt_d;
            wr_ptr_q  <= wr_ptr_d;
            words_q   <= words_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        bus.ld_ready   = (state_q == IDLE) && !bus.go;
        bus.im_wr_en   = accept;
        bus.im_addr    = wr_ptr_q;
        bus.im_dat     = bus.ld_data;
        bus.core_reset = (state_q != RUN);
        bus.core_req   = (state_q == RUN);
        bus.busy       = (state_q != IDLE);
        bus.run_done   = (state_q == DONE);
        bus.timeout    = timeout_q;
        bus.cycles     = cycles;
        bus.words      = words_q;
    end

endmodule

// File: tb/tb_core_launcher.sv
// Randomized bench for core_launcher against a cycle-schedule model of load and run behaviour.
module tb_core_launcher;

    localparam int unsigned D  = 12;
    localparam int unsigned W  = 9;
    localparam int unsigned RC = 2;
    localparam int unsigned MC = 16;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;

    int       exp_ptr   = 0;
    int       exp_words = 0;
    logic     exp_to    = 1'b0;
    logic [W-1:0] wq[$];

    core_launcher_if #(.D(D), .W(W)) bus ();

    core_launcher #(.D(D), .W(W), .RST_CYC(RC), .MAX_CYC(MC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // {core_reset, core_req, busy, run_done, ld_ready, im_wr_en, timeout}
    function automatic logic [6:0] flags();
        return {bus.core_reset, bus.core_req, bus.busy, bus.run_done,
                bus.ld_ready, bus.im_wr_en, bus.timeout};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic zero_inputs();
        bus.ld_valid  = 1'b0;
        bus.ld_data   = '0;
        bus.ld_last   = 1'b0;
        bus.go        = 1'b0;
        bus.core_done = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        #1;
        n_cmp++;
        if (flags() !== {5'b10001, 1'b0, exp_to}) begin
            n_err++;
            $display("FAIL %s_flags: got %b expected %b", tag, flags(), {5'b10001, 1'b0, exp_to});
        end
        n_cmp++;
        if (bus.words !== D'(exp_words)) begin
            n_err++;
            $display("FAIL %s_words: got %0d expected %0d", tag, bus.words, exp_words);
        end
    endtask

    task automatic test_reset();
        zero_inputs();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        exp_ptr = 0; exp_words = 0; exp_to = 1'b0;
        check_idle("reset");
        n_cmp++;
        if (bus.cycles !== 16'd0) begin
            n_err++;
            $display("FAIL reset_cycles: got %0d expected 0", bus.cycles);
        end
    endtask

    // Streams every word of wq back to back; the last carries ld_last when asked.
    task automatic load_words(input bit last);
        for (int i = 0; i < wq.size(); i++) begin
            bus.ld_valid = 1'b1;
            bus.ld_data  = wq[i];
            bus.ld_last  = last && (i == wq.size() - 1);
            #1;
            n_cmp++;
            if (!bus.ld_ready || !bus.im_wr_en || bus.im_addr !== D'(exp_ptr) || bus.im_dat !== wq[i]) begin
                n_err++;
                $display("FAIL load_write: got rdy=%b en=%b addr=%0d dat=%h expected rdy=1 en=1 addr=%0d dat=%h",
                         bus.ld_ready, bus.im_wr_en, bus.im_addr, bus.im_dat, exp_ptr, wq[i]);
            end
            if (bus.ld_last) begin
                exp_words = (exp_ptr + 1) % (1 << D);
                exp_ptr   = 0;
            end else begin
                exp_ptr = (exp_ptr + 1) % (1 << D);
            end
            step();
        end
        zero_inputs();
        check_idle("load_end");
    endtask

    task automatic test_load();
        wq = '{9'h1A3, 9'h0FF, 9'h100};
        load_words(1'b1);
        wq = '{W'($urandom)};
        load_words(1'b0);
        for (int r = 0; r < 6; r++) begin
            wq.delete();
            for (int i = 0; i < int'($urandom_range(1, 8)); i++) wq.push_back(W'($urandom));
            load_words(r % 2 == 0);
        end
    endtask

    // done_at: RUN cycle with core_done (0 = never); reset_at: RUN cycle to assert reset (0 = none).
    task automatic run_case(input int done_at, input int reset_at);
        int  k;
        bit  ended;
        logic end_to;
        bus.go       = 1'b1;
        bus.ld_valid = 1'b1;
        bus.ld_last  = 1'b1;
        bus.ld_data  = W'($urandom);
        #1;
        n_cmp++;
        if (flags() !== {5'b10000, 1'b0, exp_to}) begin
            n_err++;
            $display("FAIL go_collision: got %b expected %b", flags(), {5'b10000, 1'b0, exp_to});
        end
        step();
        for (int c = 1; c <= int'(RC); c++) begin
            bus.go = 1'($urandom); bus.ld_valid = 1'($urandom); bus.core_done = 1'($urandom);
            #1;
            n_cmp++;
            if (flags() !== 7'b1010000 || bus.cycles !== 16'd0) begin
                n_err++;
                $display("FAIL crst_cycle%0d: got %b cyc=%0d expected 1010000 cyc=0", c, flags(), bus.cycles);
            end
            step();
        end
        k = 0;
        ended = 1'b0;
        while (!ended && k < int'(MC)) begin
            k++;
            bus.go = 1'($urandom); bus.ld_valid = 1'($urandom);
            bus.core_done = (k == done_at);
            #1;
            n_cmp++;
            if (flags() !== 7'b0110000 || bus.cycles !== 16'(k - 1)) begin
                n_err++;
                $display("FAIL run_cycle%0d: got %b cyc=%0d expected 0110000 cyc=%0d", k, flags(), bus.cycles, k - 1);
            end
            if (k == reset_at) begin
                reset = 1'b1;
                step();
                reset = 1'b0;
                zero_inputs();
                exp_ptr = 0; exp_words = 0; exp_to = 1'b0;
                check_idle("midreset");
                n_cmp++;
                if (bus.cycles !== 16'd0) begin
                    n_err++;
                    $display("FAIL midreset_cycles: got %0d expected 0", bus.cycles);
                end
                return;
            end
            step();
            if (k == done_at || k == int'(MC)) ended = 1'b1;
        end
        end_to = !(done_at >= 1 && done_at <= int'(MC));
        bus.core_done = 1'b0; bus.go = 1'($urandom); bus.ld_valid = 1'($urandom);
        #1;
        n_cmp++;
        if (flags() !== {6'b101100, end_to} || bus.cycles !== 16'(k)) begin
            n_err++;
            $display("FAIL done_state: got %b cyc=%0d expected %b cyc=%0d", flags(), bus.cycles, {6'b101100, end_to}, k);
        end
        step();
        zero_inputs();
        exp_to = end_to;
        check_idle("after_run");
        n_cmp++;
        if (bus.cycles !== 16'(k)) begin
            n_err++;
            $display("FAIL hold_cycles: got %0d expected %0d", bus.cycles, k);
        end
    endtask

    task automatic test_run();
        run_case(5, 0);
    endtask

    task automatic test_timeout();
        run_case(0, 0);
        run_case(int'(MC), 0);
        run_case(1, 0);
    endtask

    task automatic test_random_runs();
        for (int r = 0; r < 8; r++) begin
            run_case(int'($urandom_range(1, MC + 4)), 0);
        end
    endtask

    task automatic test_partial_across_run();
        wq = '{W'($urandom), W'($urandom)};
        load_words(1'b0);
        run_case(3, 0);
        wq = '{W'($urandom), W'($urandom)};
        load_words(1'b1);
    endtask

    task automatic test_mid_reset();
        wq = '{W'($urandom)};
        load_words(1'b0);
        run_case(10, 3);
        wq = '{W'($urandom)};
        load_words(1'b1);
    endtask

    task automatic test_wrap();
        wq.delete();
        for (int i = 0; i < (1 << D); i++) wq.push_back(W'($urandom));
        load_words(1'b1);
        wq = '{W'($urandom)};
        load_words(1'b0);
    endtask

    initial begin
        reset = 1'b1;
        zero_inputs();
        test_reset();
        test_load();
        test_run();
        test_timeout();
        test_random_runs();
        test_partial_across_run();
        test_mid_reset();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/core_launcher.md
# core_launcher

Host-side initiator for the processor core's `req`/`done` run handshake. It streams machine-code words into the instruction memory write port, holds the core in reset while loading, releases it, and asserts `req`. It then counts run cycles until the core raises `done` or a cycle limit expires. The block sits between the test/host interface and the core top level, which it drives as the requesting end.

## Interface
Parameters:
- `D`, 12: instruction address width, matching the program counter width.
- `W`, 9: machine-code word width.
- `RST_CYC`, 2: minimum core-reset cycles after `go`; must be ≥1.
- `MAX_CYC`, 4096: RUN-cycle limit before timeout; 1..65535.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `ld_valid` in 1: load word valid.
- `ld_data` in W: machine-code word.
- `ld_last` in 1: marks the final word of a program.
- `ld_ready` out 1: load word accepted when `ld_valid && ld_ready`.
- `go` in 1: start-run pulse.
- `im_wr_en` out 1: instruction memory write enable.
- `im_addr` out D: instruction memory write address.
- `im_dat` out W: instruction memory write data.
- `core_reset` out 1: reset to the core.
- `core_req` out 1: run request to the core.
- `core_done` in 1: done from the core.
- `busy` out 1: high in any state other than IDLE.
- `run_done` out 1: one-cycle pulse when a run ends.
- `timeout` out 1: last run hit `MAX_CYC`.
- `cycles` out 16: RUN cycles of the last or current run.
- `words` out D: word count of the last completed load.

## Operation
- States: IDLE, CRST, RUN, DONE. Outputs `core_reset`, `core_req`, `busy` and `run_done` are Moore outputs, decoded from the state register only.
- **IDLE**
  - Outputs: `core_reset`=1, `core_req`=0.
  - `ld_ready = !go`, combinational. A go/load collision therefore resolves to go, and no word is written that cycle.
  - Accepted word: `im_wr_en`=1, `im_addr`=`wr_ptr`, `im_dat`=`ld_data`, all combinational in the same cycle. Then `wr_ptr` increments, wrapping modulo 2^D.
  - Accepted word with `ld_last`: `words` ← `wr_ptr`+1 (truncated to D bits), and `wr_ptr` ← 0.
  - `go`=1: clear `cycles` and `timeout`, load the reset counter with `RST_CYC`-1, go to CRST.
- **CRST**
  - Outputs: `core_reset`=1, `core_req`=0, `ld_ready`=0.
  - The reset counter decrements each cycle; go to RUN when it reaches 0. CRST lasts exactly `RST_CYC` cycles.
  - `core_done` is ignored.
- **RUN**
  - Outputs: `core_reset`=0, `core_req`=1, `ld_ready`=0.
  - `cycles` increments each cycle.
  - `core_done`=1: go to DONE, with `cycles` including this cycle.
  - If `core_done`=0 and `cycles`+1 == `MAX_CYC`: set `timeout`=1 and go to DONE.
  - `core_done` has priority over timeout when both occur in the same cycle.
- **DONE**
  - Outputs: `run_done`=1, `core_req`=0, `core_reset`=1.
  - Next state is IDLE.
  - `cycles`, `timeout` and `words` hold until the next `go` or `reset`.
- `go` outside IDLE is ignored, and `ld_valid` outside IDLE is ignored.
- `wr_ptr` is not cleared by a run. A partial load without `ld_last` continues at the same address after the run.

## Timing
- Reset values (cycle after `reset`): state IDLE, `core_reset`=1, `core_req`=0, `busy`=0, `run_done`=0, `timeout`=0, `cycles`=0, `words`=0, `wr_ptr`=0.
  - `ld_ready`=1 and `im_wr_en`=0 unless `ld_valid`.
- `reset` at any point, including mid-RUN, returns the block to IDLE next cycle with the values above. The core is re-held in reset immediately.
- `go` at cycle t:
  - CRST during t+1 .. t+`RST_CYC`.
  - RUN from t+`RST_CYC`+1, where `core_req` rises and `core_reset` falls in the same cycle.
- `core_done` in the n-th RUN cycle:
  - DONE next cycle with `cycles`=n and `run_done`=1.
  - IDLE the cycle after that.
- Load throughput: one word per cycle. Zero-latency write: the memory write happens in the handshake cycle.

## Structure
- Shared package `launch_pkg` holds:
  - `launch_state_t`, an enum over IDLE, CRST, RUN, DONE;
  - the width constant `CYC_W`=16.
- One sub-module, `run_timer`: the 16-bit RUN counter with clear, enable and limit compare, producing `limit_hit`.
- All other logic lives in `core_launcher`.

## Test plan
- Reset: assert `reset` for 2 cycles → `core_reset`=1, `core_req`=0, `busy`=0, `cycles`=0, `words`=0, `ld_ready`=1.
- Load: 0x1A3, 0x0FF, 0x100 with `ld_last` on the third → writes to addresses 0, 1, 2 with matching data; `words`=3. A following load writes address 0.
- Run: `go` with `RST_CYC`=2, `core_done` raised in the 5th RUN cycle:
  - `core_reset`=1 for 2 cycles after `go`;
  - `core_req` high for exactly 5 cycles;
  - `cycles`=5, `run_done` pulses once, `timeout`=0.
- Timeout: `MAX_CYC`=16, `core_done` held at 0 → `timeout`=1, `cycles`=16, `run_done` pulse. `core_done` asserted in the 16th cycle → `timeout`=0.
- Collision: `go` and `ld_valid` in the same cycle → `ld_ready`=0, no write, run starts. `ld_valid` and `go` during RUN → ignored.
- Mid-run reset: `reset` in the 3rd RUN cycle → IDLE next cycle, `core_reset`=1, `core_req`=0, `cycles`=0, `wr_ptr`=0.
